// File: rtl/ring_buffer_reader.sv
`default_nettype none
// ============================================================================
// ring_buffer_reader: consumer side of a memory-resident command ring.
// Optional RB_PTR_CHECK_EN rejects write pointers with non-zero upper bits.
// Revision: 1.0
// ============================================================================
module ring_buffer_reader #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 15,
    parameter int PTR_W       = 4,
    parameter int RD_PTR_ADDR = 1,
    parameter int WR_PTR_ADDR = 2,
    parameter int DATA_BASE   = 3,
    parameter int MAX_BATCH   = 4,
    parameter int TIMEOUT     = 10
) (
    input  logic              clk,
    input  logic              rst,
    output logic              mem_enable,
    output logic              mem_readWrite,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_DataWrite,
    input  logic [DATA_W-1:0] mem_DataOut,
    input  logic              mem_done,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PTR_W-1:0]  occupancy,
    output logic              timeout_err,
    output logic              ptr_err
);

    localparam int C_BATCH_W = $clog2(MAX_BATCH + 1);
    localparam int C_TIMER_W = $clog2(TIMEOUT + 1);
    localparam logic [C_BATCH_W-1:0] C_MAX_BATCH  = C_BATCH_W'(MAX_BATCH);
    localparam logic [C_TIMER_W-1:0] C_TIMER_LAST = C_TIMER_W'(TIMEOUT - 1);

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_WP_REQ   = 4'd1,
        ST_WP_WAIT  = 4'd2,
        ST_CHECK    = 4'd3,
        ST_DAT_REQ  = 4'd4,
        ST_DAT_WAIT = 4'd5,
        ST_PRESENT  = 4'd6,
        ST_WB_REQ   = 4'd7,
        ST_WB_WAIT  = 4'd8
    } state_t;

    state_t              state_q, state_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [C_BATCH_W-1:0] batch_q, batch_d;
    logic [C_TIMER_W-1:0] timer_q, timer_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                rw_q, rw_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic                valid_q, valid_d;
    logic                tmo_q, tmo_d;
    logic                perr_q, perr_d;

    logic                w_in_wait;
    logic                w_expired;
    logic                w_ptr_bad;
    logic [PTR_W-1:0]    w_rd_inc;
    logic [C_BATCH_W-1:0] w_batch_inc;

`ifdef RB_PTR_CHECK_EN
    assign w_ptr_bad = |mem_DataOut[DATA_W-1:PTR_W];
`else
    assign w_ptr_bad = 1'b0;
`endif

    assign w_in_wait   = (state_q == ST_WP_WAIT) || (state_q == ST_DAT_WAIT) || (state_q == ST_WB_WAIT);
    assign w_expired   = w_in_wait && !mem_done && (timer_q == C_TIMER_LAST);
    assign w_rd_inc    = rd_ptr_q + 1'b1;
    assign w_batch_inc = batch_q + 1'b1;

    always_comb begin
        state_d  = state_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        batch_d  = batch_q;
        timer_d  = '0;
        addr_d   = addr_q;
        rw_d     = rw_q;
        wdata_d  = wdata_q;
        data_d   = data_q;
        valid_d  = valid_q;
        tmo_d    = 1'b0;
        perr_d   = 1'b0;

        if (w_in_wait && !mem_done && !w_expired) begin
            timer_d = timer_q + 1'b1;
        end
        if (w_expired) begin
            tmo_d = 1'b1;
        end

        case (state_q)
            ST_IDLE:    state_d = ST_WP_REQ;
            ST_WP_REQ:  state_d = ST_WP_WAIT;
            ST_WP_WAIT: begin
                if (mem_done) begin
                    if (w_ptr_bad) begin
                        perr_d  = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        wr_ptr_d = mem_DataOut[PTR_W-1:0];
                        state_d  = ST_CHECK;
                    end
                end else if (w_expired) begin
                    state_d = ST_IDLE;
                end
            end
            ST_CHECK: begin
                if (rd_ptr_q == wr_ptr_q) begin
                    state_d = ST_IDLE;
                end else begin
                    batch_d = '0;
                    state_d = ST_DAT_REQ;
                end
            end
            ST_DAT_REQ: state_d = ST_DAT_WAIT;
            ST_DAT_WAIT: begin
                if (mem_done) begin
                    data_d  = mem_DataOut;
                    valid_d = 1'b1;
                    state_d = ST_PRESENT;
                end else if (w_expired) begin
                    state_d = ST_IDLE;
                end
            end
            ST_PRESENT: begin
                if (out_ready) begin
                    valid_d  = 1'b0;
                    rd_ptr_d = w_rd_inc;
                    batch_d  = w_batch_inc;
                    if ((w_rd_inc != wr_ptr_q) && (w_batch_inc < C_MAX_BATCH)) begin
                        state_d = ST_DAT_REQ;
                    end else begin
                        state_d = ST_WB_REQ;
                    end
                end
            end
            ST_WB_REQ:  state_d = ST_WB_WAIT;
            ST_WB_WAIT: begin
                if (mem_done) begin
                    state_d = ST_IDLE;
                end else if (w_expired) begin
                    // rd_ptr has already advanced, so the writeback must be retried
                    state_d = ST_WB_REQ;
                end
            end
            default:    state_d = ST_IDLE;
        endcase

        // Request fields are loaded on entry to a *_REQ state and held afterwards
        if (state_d != state_q) begin
            case (state_d)
                ST_WP_REQ: begin
                    addr_d = ADDR_W'(WR_PTR_ADDR);
                    rw_d   = 1'b1;
                end
                ST_DAT_REQ: begin
                    addr_d = ADDR_W'(DATA_BASE) + ADDR_W'(rd_ptr_d);
                    rw_d   = 1'b1;
                end
                ST_WB_REQ: begin
                    addr_d  = ADDR_W'(RD_PTR_ADDR);
                    rw_d    = 1'b0;
                    wdata_d = DATA_W'(rd_ptr_d);
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            batch_q  <= '0;
            timer_q  <= '0;
            addr_q   <= '0;
            rw_q     <= 1'b1;
            wdata_q  <= '0;
            data_q   <= '0;
            valid_q  <= 1'b0;
            tmo_q    <= 1'b0;
            perr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            batch_q  <= batch_d;
            timer_q  <= timer_d;
            addr_q   <= addr_d;
            rw_q     <= rw_d;
            wdata_q  <= wdata_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
            tmo_q    <= tmo_d;
            perr_q   <= perr_d;
        end
    end

    assign mem_enable    = (state_q == ST_WP_REQ) || (state_q == ST_DAT_REQ) || (state_q == ST_WB_REQ);
    assign mem_readWrite = rw_q;
    assign mem_address   = addr_q;
    assign mem_DataWrite = wdata_q;
    assign out_data      = data_q;
    assign out_valid     = valid_q;
    assign occupancy     = wr_ptr_q - rd_ptr_q;
    assign timeout_err   = tmo_q;
    assign ptr_err       = perr_q;

endmodule
`default_nettype wire
